// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-through, no-write-allocate data cache for the MA stage.
// A valid/ready request port in front, a word-wide backing memory port behind.
// Loads refill a whole line on a miss. Stores always go to memory, and they
// update the cached copy only when the line is already present.
// Optional feature: define DCACHE_DM_PERF_EN to add the perf_hits/perf_misses load counters.
module dcache_dm #(
    parameter logic [31:0] BASE       = 32'h10010000,
    parameter int          SETS       = 64,
    parameter int          LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_width,
    input  logic        req_ext,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef DCACHE_DM_PERF_EN
    ,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
`endif
);

    localparam int WOFF   = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int DA_W   = WOFF + IDX_W;
    localparam int TAG_LO = 2 + DA_W;
    localparam int TAG_W  = 32 - TAG_LO;
    localparam int CNT_W  = (WOFF > 0) ? WOFF : 1;
    localparam logic [DA_W-1:0]  LMASK    = DA_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} state_t;

    state_t state, next_state;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    logic [31:0]      data [SETS*LINE_WORDS];

    logic [31:0]      off_q;
    logic [1:0]       width_q;
    logic             ext_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rdata_q;
    logic             err_q;

    // Incoming request, decoded against the cache geometry
    logic [31:0]      off;
    logic [1:0]       a;
    logic [IDX_W-1:0] idx;
    logic [DA_W-1:0]  daddr;
    logic [TAG_W-1:0] tag;
    logic             misaligned;
    logic             hit;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata;

    assign off        = req_addr - BASE;
    assign a          = off[1:0];
    assign daddr      = off[2 +: DA_W];
    assign idx        = off[2 + WOFF +: IDX_W];
    assign tag        = off[31:TAG_LO];
    assign misaligned = ((req_width == 2'd1) && a[0]) || (req_width[1] && (a != 2'b00));
    assign hit        = valid[idx] && (tags[idx] == tag);
    assign st_be      = (req_width == 2'd0) ? (4'b0001 << a) :
                        (req_width == 2'd1) ? (4'b0011 << a) : 4'b1111;
    assign st_wdata   = req_wdata << {a, 3'b000};

    // Latched request, as seen during a refill
    logic [IDX_W-1:0] q_idx;
    logic [DA_W-1:0]  q_daddr;
    logic [DA_W-1:0]  fill_daddr;
    logic             fill_is_target;
    logic             fill_last;
    logic [31:0]      fill_addr;

    assign q_idx          = off_q[2 + WOFF +: IDX_W];
    assign q_daddr        = off_q[2 +: DA_W];
    assign fill_daddr     = (q_daddr & ~LMASK) | DA_W'(cnt);
    assign fill_is_target = (DA_W'(cnt) == (q_daddr & LMASK));
    assign fill_last      = (cnt == CNT_LAST);
    assign fill_addr      = ({2'b00, off_q[31:2]} & ~(32'(LINE_WORDS - 1))) | 32'(cnt);

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [1:0] wd, input logic zext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (wd)
            2'd0:    r = {{24{b[7] & ~zext}}, b};
            2'd1:    r = {{16{h[15] & ~zext}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // State register; reset abandons any refill or write in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state decision and all port outputs, which are zero outside their own state
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_be     = 4'd0;
        mem_wdata  = 32'd0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (misaligned)  next_state = RESP;
                    else if (req_we) next_state = WRITE;
                    else if (hit)    next_state = RESP;
                    else             next_state = REFILL;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = fill_addr;
                if (mem_ack && fill_last) next_state = RESP;
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {2'b00, off_q[31:2]};
                mem_be    = be_q;
                mem_wdata = wdata_q;
                if (mem_ack) next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request latch, refill word counter, response data and line valid bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid   <= '0;
            off_q   <= '0;
            width_q <= '0;
            ext_q   <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        off_q   <= off;
                        width_q <= req_width;
                        ext_q   <= req_ext;
                        be_q    <= st_be;
                        wdata_q <= st_wdata;
                        cnt     <= '0;
                        rdata_q <= '0;
                        err_q   <= misaligned;
                        if (!misaligned && !req_we) begin
                            if (hit) rdata_q <= load_ext(data[daddr], a, req_width, req_ext);
                            else     valid[idx] <= 1'b0;
                        end
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        if (fill_is_target) rdata_q <= load_ext(mem_rdata, off_q[1:0], width_q, ext_q);
                        if (fill_last) valid[q_idx] <= 1'b1;
                        else           cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays: store-hit byte merge on accept, refill words as they arrive
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid && req_we && !misaligned && hit) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) data[daddr][8*i +: 8] <= st_wdata[8*i +: 8];
            end
        end
        if (state == REFILL && mem_ack) begin
            data[fill_daddr] <= mem_rdata;
            if (fill_last) tags[q_idx] <= off_q[31:TAG_LO];
        end
    end

`ifdef DCACHE_DM_PERF_EN
    // Aligned-load hit/miss counters, bumped when the IDLE decision is made
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else if (state == IDLE && req_valid && !req_we && !misaligned) begin
            if (hit) perf_hits   <= perf_hits + 32'd1;
            else     perf_misses <= perf_misses + 32'd1;
        end
    end
`endif

endmodule
